// File: rtl/xava_issue_scheduler.sv
// In-order X-IF to APU issue scheduler: queues issued instructions, waits for
// commit/kill, dispatches one at a time to the accelerator and returns results.
module xava_issue_scheduler #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ID_W  = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            issue_valid_i,
   output logic            issue_ready_o,
   input  logic [31:0]     issue_instr_i,
   input  logic [31:0]     issue_rs0_i,
   input  logic [31:0]     issue_rs1_i,
   input  logic [ID_W-1:0] issue_id_i,
   output logic            issue_accept_o,
   output logic            issue_writeback_o,
   input  logic            commit_valid_i,
   input  logic [ID_W-1:0] commit_id_i,
   input  logic            commit_kill_i,
   output logic            apu_req_o,
   input  logic            apu_gnt_i,
   output logic [95:0]     apu_operands_o,
   input  logic            apu_rvalid_i,
   input  logic [31:0]     apu_result_i,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic [ID_W-1:0] result_id_o,
   output logic [31:0]     result_data_o,
   output logic [4:0]      result_rd_o,
   output logic            result_we_o,
   output logic            busy_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

   state_e            state_q, state_d;
   logic [31:0]       instr_q [DEPTH];
   logic [31:0]       rs0_q   [DEPTH];
   logic [31:0]       rs1_q   [DEPTH];
   logic [ID_W-1:0]   id_q    [DEPTH];
   logic [DEPTH-1:0]  wb_q, committed_q, killed_q;
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ready_q;
   logic [31:0]       res_data_q;
   logic [ID_W-1:0]   res_id_q;
   logic [4:0]        res_rd_q;

   logic              push, pop, capture;
   logic              cm_hit, cm_old, cm_new;
   logic [PTR_W-1:0]  cm_idx, scan_idx;

   assign push              = issue_valid_i && ready_q;
   assign issue_ready_o     = ready_q;
   assign issue_accept_o    = 1'b1;
   assign issue_writeback_o = (issue_instr_i[31:26] == 6'b010000);
   assign count_d           = count_q + CNT_W'(push) - CNT_W'(pop);

   // Oldest live entry whose id matches the commit id.
   always_comb begin
      cm_hit   = 1'b0;
      cm_idx   = '0;
      scan_idx = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         scan_idx = head_q + PTR_W'(k);
         if (!cm_hit && (CNT_W'(k) < count_q) && (id_q[scan_idx] == commit_id_i)) begin
            cm_hit = 1'b1;
            cm_idx = scan_idx;
         end
      end
   end

   assign cm_old = commit_valid_i && cm_hit && !committed_q[cm_idx] && !killed_q[cm_idx];
   assign cm_new = commit_valid_i && !cm_hit && push && (issue_id_i == commit_id_i);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               if (killed_q[head_q])         pop = 1'b1;
               else if (committed_q[head_q]) state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (apu_gnt_i) begin
               if (wb_q[head_q]) begin
                  state_d = S_WAIT;
               end else begin
                  pop     = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            if (apu_rvalid_i) begin
               capture = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (result_ready_i) begin
               pop     = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ready_q     <= 1'b0;
         committed_q <= '0;
         killed_q    <= '0;
         res_data_q  <= '0;
         res_id_q    <= '0;
         res_rd_q    <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_q + PTR_W'(pop);
         tail_q  <= tail_q + PTR_W'(push);
         count_q <= count_d;
         ready_q <= (count_d < CNT_W'(DEPTH));
         if (push) begin
            committed_q[tail_q] <= cm_new && !commit_kill_i;
            killed_q[tail_q]    <= cm_new && commit_kill_i;
         end
         if (cm_old) begin
            committed_q[cm_idx] <= !commit_kill_i;
            killed_q[cm_idx]    <= commit_kill_i;
         end
         if (capture) begin
            res_data_q <= apu_result_i;
            res_id_q   <= id_q[head_q];
            res_rd_q   <= instr_q[head_q][11:7];
         end
      end
   end

   // Payload storage; validity is tracked by count_q, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_q[tail_q] <= issue_instr_i;
         rs0_q[tail_q]   <= issue_rs0_i;
         rs1_q[tail_q]   <= issue_rs1_i;
         id_q[tail_q]    <= issue_id_i;
         wb_q[tail_q]    <= issue_writeback_o;
      end
   end

   assign apu_req_o      = (state_q == S_REQ);
   assign apu_operands_o = apu_req_o ? {rs1_q[head_q], rs0_q[head_q], instr_q[head_q]} : '0;
   assign result_valid_o = (state_q == S_RESP);
   assign result_we_o    = result_valid_o;
   assign result_data_o  = res_data_q;
   assign result_id_o    = res_id_q;
   assign result_rd_o    = res_rd_q;
   assign busy_o         = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_xava_issue_scheduler.sv
// Self-checking bench for xava_issue_scheduler: table-driven issue/commit/dispatch
// flows with dispatch/result scoreboards, plus hand-written queue corner cases.
module tb_xava_issue_scheduler;

   localparam int unsigned ID_W = 4;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            issue_valid_i, issue_ready_o, issue_accept_o, issue_writeback_o;
   logic [31:0]     issue_instr_i, issue_rs0_i, issue_rs1_i;
   logic [ID_W-1:0] issue_id_i, commit_id_i, result_id_o;
   logic            commit_valid_i, commit_kill_i;
   logic            apu_req_o, apu_gnt_i, apu_rvalid_i;
   logic [95:0]     apu_operands_o;
   logic [31:0]     apu_result_i, result_data_o;
   logic            result_valid_o, result_ready_i, result_we_o, busy_o;
   logic [4:0]      result_rd_o;

   xava_issue_scheduler #(.DEPTH(4), .ID_W(ID_W)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_instr_i(issue_instr_i), .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
      .issue_id_i(issue_id_i), .issue_accept_o(issue_accept_o),
      .issue_writeback_o(issue_writeback_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
      .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_operands_o(apu_operands_o),
      .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
      .result_we_o(result_we_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]     instr;
      logic [31:0]     rs0;
      logic [31:0]     rs1;
      logic [ID_W-1:0] id;
      logic [31:0]     result;
      logic            exp_wb;
      logic [4:0]      exp_rd;
   } vec_t;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [4:0]      rd;
      logic [31:0]     data;
   } res_t;

   vec_t        vecs [5];
   logic [95:0] disp_q [$];
   res_t        res_q  [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Dispatch scoreboard: every grant must match the oldest expected operand set.
   always @(negedge clk) begin
      if (rst_ni && apu_req_o && apu_gnt_i) begin
         if (disp_q.size() == 0) begin
            check("unexpected_dispatch", apu_operands_o, 96'h0);
         end else begin
            logic [95:0] e;
            e = disp_q.pop_front();
            check("dispatch_operands", apu_operands_o, e);
         end
      end
   end

   // Result scoreboard: every result handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_ni && result_valid_o && result_ready_i) begin
         if (res_q.size() == 0) begin
            check("unexpected_result", {result_id_o, result_rd_o, result_data_o}, 96'h0);
         end else begin
            res_t r;
            r = res_q.pop_front();
            check("result_id",   96'(result_id_o),   96'(r.id));
            check("result_rd",   96'(result_rd_o),   96'(r.rd));
            check("result_data", 96'(result_data_o), 96'(r.data));
            check("result_we",   96'(result_we_o),   96'd1);
         end
      end
   end

   task automatic do_issue(input logic [31:0] instr, input logic [31:0] rs0,
                           input logic [31:0] rs1, input logic [ID_W-1:0] id,
                           input logic exp_wb);
      int n;
      n = 0;
      while (!issue_ready_o && n < 50) begin
         tick();
         n++;
      end
      if (!issue_ready_o) check("issue_ready_timeout", 96'(issue_ready_o), 96'd1);
      issue_valid_i = 1'b1;
      issue_instr_i = instr;
      issue_rs0_i   = rs0;
      issue_rs1_i   = rs1;
      issue_id_i    = id;
      #1;
      check("issue_writeback", 96'(issue_writeback_o), 96'(exp_wb));
      check("issue_accept",    96'(issue_accept_o),    96'd1);
      tick();
      issue_valid_i = 1'b0;
   endtask

   task automatic do_commit(input logic [ID_W-1:0] id, input logic kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      tick();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!apu_req_o && n < 30) begin
         tick();
         n++;
      end
      if (!apu_req_o) check("apu_req_timeout", 96'(apu_req_o), 96'd1);
   endtask

   task automatic grant();
      apu_gnt_i = 1'b1;
      tick();
      apu_gnt_i = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [95:0] ops;
      ops = {v.rs1, v.rs0, v.instr};
      disp_q.push_back(ops);
      if (v.exp_wb) res_q.push_back('{v.id, v.exp_rd, v.result});
      do_issue(v.instr, v.rs0, v.rs1, v.id, v.exp_wb);
      do_commit(v.id, 1'b0);
      wait_req();
      for (int c = 0; c < 2; c++) begin
         check("req_held",      96'(apu_req_o), 96'd1);
         check("operands_held", apu_operands_o, ops);
         tick();
      end
      grant();
      check("no_early_result", 96'(result_valid_o), 96'd0);
      if (v.exp_wb) begin
         tick();
         apu_rvalid_i = 1'b1;
         apu_result_i = v.result;
         tick();
         apu_rvalid_i = 1'b0;
         apu_result_i = 32'h0;
         for (int c = 0; c < 3; c++) begin
            check("result_valid_hold", 96'(result_valid_o), 96'd1);
            check("result_data_hold",  96'(result_data_o),  96'(v.result));
            check("result_id_hold",    96'(result_id_o),    96'(v.id));
            check("result_rd_hold",    96'(result_rd_o),    96'(v.exp_rd));
            tick();
         end
         result_ready_i = 1'b1;
         tick();
         result_ready_i = 1'b0;
      end
      check("result_valid_after", 96'(result_valid_o), 96'd0);
      check("busy_after",         96'(busy_o),         96'd0);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0257, 32'h1111_1111, 32'h2222_2222, 4'd1,  32'h0,         1'b0, 5'd4};
      vecs[1] = '{32'h4000_02D7, 32'h3333_3333, 32'h4444_4444, 4'd2,  32'hDEAD_BEEF, 1'b1, 5'd5};
      vecs[2] = '{32'h4000_0F57, 32'h5555_5555, 32'h6666_6666, 4'd7,  32'h1234_5678, 1'b1, 5'd30};
      vecs[3] = '{32'h4400_0857, 32'h7777_7777, 32'h8888_8888, 4'd9,  32'h0,         1'b0, 5'd16};
      vecs[4] = '{32'hC000_0057, 32'h9999_9999, 32'hAAAA_AAAA, 4'd15, 32'h0,         1'b0, 5'd0};

      rst_ni = 1'b0;
      issue_valid_i = 1'b0; issue_instr_i = '0; issue_rs0_i = '0; issue_rs1_i = '0;
      issue_id_i = '0; commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
      apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0; apu_result_i = '0; result_ready_i = 1'b0;
      repeat (3) tick();
      check("rst_issue_ready",  96'(issue_ready_o),  96'd0);
      check("rst_apu_req",      96'(apu_req_o),      96'd0);
      check("rst_result_valid", 96'(result_valid_o), 96'd0);
      check("rst_busy",         96'(busy_o),         96'd0);
      check("rst_operands",     apu_operands_o,      96'd0);
      rst_ni = 1'b1;
      tick();
      check("ready_after_rst", 96'(issue_ready_o), 96'd1);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Fill the queue with uncommitted entries, then kill the head.
      for (int i = 0; i < 4; i++)
         do_issue(32'h0000_0057 | (32'(i) << 7), 32'(i), 32'(i + 100), ID_W'(i), 1'b0);
      check("full_not_ready", 96'(issue_ready_o), 96'd0);
      check("full_busy",      96'(busy_o),        96'd1);
      do_commit(4'd0, 1'b1);
      check("kill_ready_lag", 96'(issue_ready_o), 96'd0);
      tick();
      check("kill_frees_slot", 96'(issue_ready_o), 96'd1);
      check("kill_no_req",     96'(apu_req_o),     96'd0);

      // Out-of-order commits: id 3 before id 2, with id 1 killed out of the way.
      do_commit(4'd1, 1'b1);
      do_commit(4'd3, 1'b0);
      for (int c = 0; c < 4; c++) begin
         check("ooo_no_req", 96'(apu_req_o), 96'd0);
         tick();
      end
      disp_q.push_back({32'd102, 32'd2, 32'h0000_0157});
      disp_q.push_back({32'd103, 32'd3, 32'h0000_01D7});
      do_commit(4'd2, 1'b0);
      wait_req();
      grant();
      wait_req();
      grant();
      check("ooo_busy_after", 96'(busy_o), 96'd0);

      // Issue and commit of the same id in one cycle.
      disp_q.push_back({32'hB2, 32'hB1, 32'h0000_0357});
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_0357; issue_rs0_i = 32'hB1;
      issue_rs1_i = 32'hB2; issue_id_i = 4'd6;
      commit_valid_i = 1'b1; commit_id_i = 4'd6; commit_kill_i = 1'b0;
      tick();
      issue_valid_i = 1'b0; commit_valid_i = 1'b0;
      check("same_cycle_req_t1", 96'(apu_req_o), 96'd0);
      tick();
      check("same_cycle_req_t2", 96'(apu_req_o), 96'd1);
      grant();
      check("same_cycle_busy", 96'(busy_o), 96'd0);

      // Reset while waiting for a writeback result; the late rvalid must be ignored.
      disp_q.push_back({32'hC2, 32'hC1, 32'h4000_0457});
      do_issue(32'h4000_0457, 32'hC1, 32'hC2, 4'd5, 1'b1);
      do_commit(4'd5, 1'b0);
      wait_req();
      grant();
      check("wait_busy", 96'(busy_o), 96'd1);
      rst_ni = 1'b0;
      repeat (2) tick();
      rst_ni = 1'b1;
      apu_rvalid_i = 1'b1; apu_result_i = 32'hFEED_F00D;
      tick();
      apu_rvalid_i = 1'b0;
      check("rst_wait_no_result", 96'(result_valid_o), 96'd0);
      tick();
      check("rst_wait_no_result2", 96'(result_valid_o), 96'd0);
      check("rst_wait_busy",       96'(busy_o),         96'd0);
      check("rst_wait_ready",      96'(issue_ready_o),  96'd1);

      check("disp_scoreboard_empty", 96'(disp_q.size()), 96'd0);
      check("res_scoreboard_empty",  96'(res_q.size()),  96'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xava_issue_scheduler.md
Name: xava_issue_scheduler

Overview:
- Sequences X-IF coprocessor instructions into the AVA accelerator's APU-style port (apu_req/apu_gnt/apu_rvalid).
- Buffers issued instructions in an in-order queue and holds each one until the core commits or kills it.
- Dispatches committed instructions one at a time, then returns writeback results on the X-IF result channel with correct id/rd and full result_ready backpressure.
- Sits between the X-IF issue/commit/result channels and accelerator_top, replacing direct issue_valid->apu_req wiring.

Parameters:
DEPTH, 4, instruction queue entries (power of 2, >=2)
ID_W, 4, X-IF instruction id width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  reset; one clock; reset is synchronous and active-low
issue_valid_i  in  1  X-IF issue request valid
issue_ready_o  out  1  queue can accept (count < DEPTH)
issue_instr_i  in  32  instruction word
issue_rs0_i  in  32  scalar operand rs1
issue_rs1_i  in  32  scalar operand rs2
issue_id_i  in  ID_W  instruction id
issue_accept_o  out  1  constant 1
issue_writeback_o  out  1  combinational: issue_instr_i[31:26]==6'b010000
commit_valid_i  in  1  commit valid
commit_id_i  in  ID_W  id being committed
commit_kill_i  in  1  1=kill, 0=commit
apu_req_o  out  1  dispatch request to accelerator
apu_gnt_i  in  1  accelerator accepted request
apu_operands_o  out  96  {rs1, rs0, instr}, [31:0]=instr
apu_rvalid_i  in  1  accelerator result valid (writeback instrs only)
apu_result_i  in  32  accelerator result
result_valid_o  out  1  X-IF result valid
result_ready_i  in  1  core accepts result
result_id_o  out  ID_W  id of result
result_data_o  out  32  result data
result_rd_o  out  5  instr[11:7] of the completing instruction
result_we_o  out  1  constant 1 while result_valid_o
busy_o  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset values: issue_ready_o=0 during reset, 1 after; all other outputs 0. Queue emptied; FSM=IDLE. Reset mid-dispatch abandons the entry; any late apu_rvalid_i is ignored because the FSM is not in WAIT.
- Queue entry fields: instr, rs0, rs1, id, wb flag, committed, killed.
- Push on issue_valid_i && issue_ready_o. No same-cycle bypass: when full, ready stays 0 even if a pop occurs that cycle.
- Commit/kill: on commit_valid_i, the oldest valid entry with id==commit_id_i gets committed=1, or killed=1 if commit_kill_i. This includes an entry pushed in the same cycle with that id. No match: ignored. A second commit on an already-committed entry is ignored.
- FSM IDLE: head killed -> pop, stay IDLE (1 cycle per killed entry). Head committed -> REQ. Otherwise stay.
- FSM REQ: apu_req_o=1 and apu_operands_o from head, held stable until apu_gnt_i. On grant: wb=0 -> pop, IDLE; wb=1 -> WAIT.
- FSM WAIT: on apu_rvalid_i, capture apu_result_i, head id and rd into result registers -> RESP. apu_rvalid_i in any other state is ignored.
- FSM RESP: result_valid_o=1 with data/id/rd stable until result_ready_i. On the handshake: pop, IDLE.
- Latency: commit sampled at edge E -> apu_req_o high no earlier than cycle E+2 (IDLE sees committed, then REQ). apu_rvalid_i in cycle R -> result_valid_o in R+1.
- Strictly in-order, at most one instruction in flight at the accelerator. Pointers wrap modulo DEPTH; count ranges 0..DEPTH.

Test Plan:
- Reset, then issue vadd.vv (funct6=000000, id=1), commit id=1 -> issue_writeback_o=0; apu_req_o held until apu_gnt_i; pop; result_valid_o never asserts; busy_o=0 after.
- Issue funct6=010000, rd=5, id=2, commit, apu_gnt_i, then apu_rvalid_i with 0xDEADBEEF -> next cycle result_valid_o=1, data=0xDEADBEEF, rd=5, id=2; hold result_ready_i=0 for 3 cycles -> outputs stable; ready=1 -> pop.
- Issue ids 0..3 with no commit -> issue_ready_o=0 after the 4th; kill id 0 -> one slot frees, issue_ready_o=1 one cycle later; apu_req_o never asserts for id 0.
- Commit out of order (id 3 before id 2, both queued) -> no dispatch until id 2's commit; then 2 dispatches before 3.
- Issue and commit the same id in the same cycle -> entry committed; apu_req_o high 2 cycles later.
- Assert rst_ni=0 while in WAIT, then pulse apu_rvalid_i -> queue empty, result_valid_o stays 0.
